lsu: RTL and testbench

Load/store unit in the EX stage, consuming the memory-access fields registered by the ID/EX pipeline register. Computes the effective address, drives a single-outstanding request/grant/response data bus, and holds the pipeline while an access is in flight. Load data is aligned, extended and registered, then presented to the writeback path.

---
 rtl/rv32_pkg.sv | 34 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu.sv | 176 +++++++++++++++++
 tb/tb_lsu.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32 load/store funct3 encodings and the LSU state type,
// shared between the decoder and the load/store unit.
package rv32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Access width lives in funct3[1:0]; funct3[2] marks zero-extending loads.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic op_legal(input logic we, input logic re, input logic [2:0] size);
    logic ok;
    ok = 1'b0;
    if (we && !re) begin
      ok = (size == F3_LB) || (size == F3_LH) || (size == F3_LW);
    end else if (re && !we) begin
      ok = (size == F3_LB) || (size == F3_LH) || (size == F3_LW) ||
           (size == F3_LBU) || (size == F3_LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store byte-lane/enable generation and load byte/half extraction
// with sign or zero extension. Purely combinational.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_sext;

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be    = st_off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // The offset here is already naturally aligned for halfwords.
  always_comb begin
    ld_byte = rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    ld_sext = ~ld_size[2];
    case (ld_size[1:0])
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ld_sext}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15] & ld_sext}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: EX-stage load/store unit driving a single-outstanding req/gnt/rvalid bus.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module lsu
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       op1_i,
  input  logic [31:0]       op2_i,
  input  logic [31:0]       mem_data_i,
  input  logic [2:0]        mem_size_i,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              flush_i,
  output logic              hold_flag_o,
  output logic              bus_req_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  output logic [4:0]        rd_addr_o,
  output logic [31:0]       rd_data_o,
  output logic              reg_wen_o,
  output logic              misalign_o
);

  lsu_state_t  state;
  logic [31:0] ea;
  logic [1:0]  off;
  logic [1:0]  off_eff;
  logic        op_valid;
  logic        suppress;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        op_load;
  logic [2:0]  op_size;
  logic [1:0]  op_off;
  logic [4:0]  op_rd;
  logic        discard;

  assign ea       = op1_i + op2_i;
  assign off      = ea[1:0];
  assign op_valid = op_legal(mem_we_i, mem_re_i, mem_size_i);

  always_comb begin
    case (mem_size_i[1:0])
      SZ_HALF: off_eff = {off[1], 1'b0};
      SZ_WORD: off_eff = 2'b00;
      default: off_eff = off;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  logic trap;

  assign trap       = ((mem_size_i[1:0] == SZ_HALF) && off[0]) ||
                      ((mem_size_i[1:0] == SZ_WORD) && (off != 2'b00));
  // The trapped op is still presented the next cycle; ignore it once.
  assign suppress   = misalign_q;
  assign misalign_o = misalign_q;
`else
  assign suppress   = 1'b0;
  assign misalign_o = 1'b0;
`endif

  lsu_align u_align (
    .st_size (mem_size_i[1:0]),
    .st_off  (off_eff),
    .st_data (mem_data_i),
    .ld_size (op_size),
    .ld_off  (op_off),
    .rdata   (bus_rdata_i),
    .be      (st_be),
    .wdata   (st_wdata),
    .ld_data (ld_data)
  );

  always_comb begin
    hold_flag_o = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    hold_flag_o = op_valid && !flush_i && !suppress;
        REQ:     hold_flag_o = !(!op_load && bus_gnt_i);
        WAIT:    hold_flag_o = !bus_rvalid_i;
        default: hold_flag_o = 1'b0;
      endcase
    end
  end

  // A grant wins over a coincident flush: stores complete, loads drain with discard set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_addr_o  <= '0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      rd_addr_o   <= '0;
      rd_data_o   <= '0;
      reg_wen_o   <= 1'b0;
      op_load     <= 1'b0;
      op_size     <= '0;
      op_off      <= '0;
      op_rd       <= '0;
      discard     <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      reg_wen_o <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (op_valid && !flush_i && !suppress) begin
`ifdef LSU_MISALIGN_TRAP_EN
            if (trap) misalign_q <= 1'b1;
            else
`endif
            begin
              state       <= REQ;
              bus_req_o   <= 1'b1;
              bus_addr_o  <= {ea[ADDR_W-1:2], 2'b00};
              bus_we_o    <= mem_we_i;
              bus_be_o    <= st_be;
              bus_wdata_o <= st_wdata;
              op_load     <= mem_re_i;
              op_size     <= mem_size_i;
              op_off      <= off_eff;
              op_rd       <= rd_addr_i;
              discard     <= 1'b0;
            end
          end
        end
        REQ: begin
          if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            if (op_load) begin
              state   <= WAIT;
              discard <= flush_i;
            end else begin
              state <= IDLE;
            end
          end else if (flush_i) begin
            bus_req_o <= 1'b0;
            state     <= IDLE;
          end
        end
        WAIT: begin
          if (bus_rvalid_i) begin
            state <= IDLE;
            if (!discard && !flush_i) begin
              reg_wen_o <= 1'b1;
              rd_addr_o <= op_rd;
              rd_data_o <= ld_data;
            end
          end else if (flush_i) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed test-plan sequences with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the LSU.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [31:0] memData = '0;
  logic [2:0]  memSize = '0;
  logic        memWe = 1'b0;
  logic        memRe = 1'b0;
  logic [4:0]  rdAddrIn = '0;
  logic        flush = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic        holdFlag;
  logic        busReq;
  logic [31:0] busAddr;
  logic        busWe;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic [4:0]  rdAddrOut;
  logic [31:0] rdDataOut;
  logic        regWen;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  bit modelOn = 1'b0;

  lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .op1_i        (op1),
    .op2_i        (op2),
    .mem_data_i   (memData),
    .mem_size_i   (memSize),
    .mem_we_i     (memWe),
    .mem_re_i     (memRe),
    .rd_addr_i    (rdAddrIn),
    .flush_i      (flush),
    .hold_flag_o  (holdFlag),
    .bus_req_o    (busReq),
    .bus_addr_o   (busAddr),
    .bus_we_o     (busWe),
    .bus_be_o     (busBe),
    .bus_wdata_o  (busWdata),
    .bus_gnt_i    (gnt),
    .bus_rvalid_i (rvalid),
    .bus_rdata_i  (rdata),
    .rd_addr_o    (rdAddrOut),
    .rd_data_o    (rdDataOut),
    .reg_wen_o    (regWen),
    .misalign_o   (misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic bit legalOp(input logic we, input logic re, input logic [2:0] size);
    if (we == re) return 1'b0;
    if (we) return size <= 3'd2;
    return (size <= 3'd2) || (size == 3'd4) || (size == 3'd5);
  endfunction

  function automatic int unsigned accBytes(input logic [2:0] size);
    if (size == 3'd0 || size == 3'd4) return 1;
    if (size == 3'd1 || size == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [1:0] alignedOff(input logic [2:0] size, input logic [1:0] off);
    int unsigned n;
    n = accBytes(size);
    return 2'((int'(off) / n) * n);
  endfunction

  function automatic bit isMisaligned(input logic [2:0] size, input logic [1:0] off);
    return (int'(off) % accBytes(size)) != 0;
  endfunction

  function automatic logic [3:0] laneBe(input logic [2:0] size, input logic [1:0] off);
    int unsigned n;
    n = accBytes(size);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] laneData(input logic [2:0] size, input logic [31:0] d);
    int unsigned n;
    n = accBytes(size);
    if (n == 1) return (d % 256) * 32'h0101_0101;
    if (n == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] size, input logic [1:0] off, input logic [31:0] word);
    int unsigned w;
    int unsigned v;
    w = word >> (8 * off);
    case (size)
      3'd0: begin v = w % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd4: v = w % 256;
      3'd1: begin v = w % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd5: v = w % 65536;
      default: v = word;
    endcase
    return v;
  endfunction

  bit          mPend = 0, mGranted = 0, mDiscard = 0, mLoad = 0;
  logic [2:0]  mSize = '0;
  logic [1:0]  mOff = '0;
  logic [4:0]  mRd = '0;
  bit          eReq = 0, eWe = 0, eWen = 0, eMis = 0, expHoldLast = 0, flushLast = 0;
  logic [31:0] eAddr = '0, eWdata = '0, eRdData = '0;
  logic [3:0]  eBe = '0;
  logic [4:0]  eRdAddr = '0;

  function automatic bit modelHold();
    if (rst) return 1'b0;
    if (!mPend) return legalOp(memWe, memRe, memSize) && !flush && !eMis;
    if (!mGranted) return !(!mLoad && gnt);
    return !rvalid;
  endfunction

  task automatic modelStep();
    logic [31:0] ea;
    logic [1:0]  off;
    bit          misNow;
    if (rst) begin
      mPend = 0; mGranted = 0; mDiscard = 0;
      eReq = 0; eWe = 0; eWen = 0; eMis = 0;
      eAddr = '0; eWdata = '0; eBe = '0; eRdAddr = '0; eRdData = '0;
    end else begin
      misNow = eMis;
      eMis = 0;
      eWen = 0;
      ea  = op1 + op2;
      off = ea[1:0];
      if (!mPend) begin
        if (legalOp(memWe, memRe, memSize) && !flush && !misNow) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (isMisaligned(memSize, off)) eMis = 1;
          else
`endif
          begin
            mPend = 1; mGranted = 0; mDiscard = 0;
            mLoad = memRe; mSize = memSize; mOff = alignedOff(memSize, off); mRd = rdAddrIn;
            eReq = 1; eAddr = ea & 32'hFFFF_FFFC; eWe = memWe;
            if (memWe) begin
              eBe = laneBe(memSize, mOff);
              eWdata = laneData(memSize, memData);
            end
          end
        end
      end else if (!mGranted) begin
        if (gnt) begin
          eReq = 0;
          if (mLoad) begin mGranted = 1; mDiscard = flush; end
          else mPend = 0;
        end else if (flush) begin
          eReq = 0;
          mPend = 0;
        end
      end else begin
        if (rvalid) begin
          mPend = 0;
          if (!mDiscard && !flush) begin
            eWen = 1; eRdAddr = mRd; eRdData = extract(mSize, mOff, rdata);
          end
        end else if (flush) begin
          mDiscard = 1;
        end
      end
    end
  endtask

  // Compare process: checks every cycle at the falling edge, then advances the model.
  always @(negedge clk) begin
    expHoldLast = modelHold();
    flushLast   = flush;
    if (modelOn) begin
      checkOutput("m_hold", {31'd0, holdFlag}, {31'd0, expHoldLast});
      checkOutput("m_req", {31'd0, busReq}, {31'd0, eReq});
      checkOutput("m_wen", {31'd0, regWen}, {31'd0, eWen});
      checkOutput("m_mis", {31'd0, misalign}, {31'd0, eMis});
      checkOutput("m_rd_addr", {27'd0, rdAddrOut}, {27'd0, eRdAddr});
      checkOutput("m_rd_data", rdDataOut, eRdData);
      if (eReq) begin
        checkOutput("m_addr", busAddr, eAddr);
        checkOutput("m_we", {31'd0, busWe}, {31'd0, eWe});
        if (eWe) begin
          checkOutput("m_be", {28'd0, busBe}, {28'd0, eBe});
          checkOutput("m_wdata", busWdata, eWdata);
        end
      end
    end
    modelStep();
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic we, input logic re, input logic [2:0] size,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] d, input logic [4:0] rd);
    memWe = we; memRe = re; memSize = size; op1 = a; op2 = b; memData = d; rdAddrIn = rd;
  endtask

  task automatic clearOp();
    memWe = 1'b0; memRe = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runLoad(input string tag, input logic [2:0] size, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int gntDelay,
                         input logic [31:0] word, input logic [31:0] expAddr,
                         input logic [31:0] expData);
    applyStimulus(1'b0, 1'b1, size, a, b, 32'h0, rd);
    gnt = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_c0_hold"}, {31'd0, holdFlag}, 32'd1);
    for (int i = 0; i < gntDelay; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput({tag, "_wait_gnt_req"}, {31'd0, busReq}, 32'd1);
    end
    nextCycle();
    gnt = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_gnt_addr"}, busAddr, expAddr);
    checkOutput({tag, "_gnt_hold"}, {31'd0, holdFlag}, 32'd1);
    nextCycle();
    gnt = 1'b0; rvalid = 1'b1; rdata = word;
    @(negedge clk);
    checkOutput({tag, "_rvalid_hold"}, {31'd0, holdFlag}, 32'd0);
    checkOutput({tag, "_rvalid_wen"}, {31'd0, regWen}, 32'd0);
    nextCycle();
    rvalid = 1'b0; clearOp();
    @(negedge clk);
    checkOutput({tag, "_wen"}, {31'd0, regWen}, 32'd1);
    checkOutput({tag, "_rd_data"}, rdDataOut, expData);
    checkOutput({tag, "_rd_addr"}, {27'd0, rdAddrOut}, {27'd0, rd});
    nextCycle();
    @(negedge clk);
    checkOutput({tag, "_wen_pulse"}, {31'd0, regWen}, 32'd0);
    nextCycle();
  endtask

  task automatic runStore(input string tag, input logic [2:0] size, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] d,
                          input logic [31:0] expAddr, input logic [3:0] expBe,
                          input logic [31:0] expWdata);
    applyStimulus(1'b1, 1'b0, size, a, b, d, 5'd0);
    gnt = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_c0_hold"}, {31'd0, holdFlag}, 32'd1);
    checkOutput({tag, "_c0_req"}, {31'd0, busReq}, 32'd0);
    nextCycle();
    gnt = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_c1_req"}, {31'd0, busReq}, 32'd1);
    checkOutput({tag, "_c1_hold"}, {31'd0, holdFlag}, 32'd0);
    checkOutput({tag, "_addr"}, busAddr, expAddr);
    checkOutput({tag, "_we"}, {31'd0, busWe}, 32'd1);
    checkOutput({tag, "_be"}, {28'd0, busBe}, {28'd0, expBe});
    checkOutput({tag, "_wdata"}, busWdata, expWdata);
    nextCycle();
    gnt = 1'b0; clearOp();
    @(negedge clk);
    checkOutput({tag, "_c2_req"}, {31'd0, busReq}, 32'd0);
    nextCycle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    nextCycle();
    modelOn = 1'b1;
    @(negedge clk);
    checkOutput("rst_hold", {31'd0, holdFlag}, 32'd0);
    checkOutput("rst_req", {31'd0, busReq}, 32'd0);
    checkOutput("rst_addr", busAddr, 32'd0);
    checkOutput("rst_wen", {31'd0, regWen}, 32'd0);
    checkOutput("rst_rd_data", rdDataOut, 32'd0);
    nextCycle();
    rst = 1'b0;

    runStore("sw", 3'b010, 32'h0000_00F0, 32'h0000_0010, 32'hDEAD_BEEF,
             32'h0000_0100, 4'b1111, 32'hDEAD_BEEF);
    runStore("sb", 3'b000, 32'h0000_0100, 32'h0000_0003, 32'h0000_00A5,
             32'h0000_0100, 4'b1000, 32'hA5A5_A5A5);
    runLoad("lb", 3'b000, 32'h0000_0200, 32'h0000_0002, 5'd5, 2,
            32'h0080_0000, 32'h0000_0200, 32'hFFFF_FF80);
    runLoad("lbu", 3'b100, 32'h0000_0200, 32'h0000_0002, 5'd6, 2,
            32'h0080_0000, 32'h0000_0200, 32'h0000_0080);

`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0300, 32'h0000_0001, 32'h0, 5'd7);
    @(negedge clk);
    checkOutput("lh_trap_c0_hold", {31'd0, holdFlag}, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("lh_trap_mis", {31'd0, misalign}, 32'd1);
    checkOutput("lh_trap_req", {31'd0, busReq}, 32'd0);
    checkOutput("lh_trap_c1_hold", {31'd0, holdFlag}, 32'd0);
    nextCycle();
    clearOp();
    @(negedge clk);
    checkOutput("lh_trap_mis_pulse", {31'd0, misalign}, 32'd0);
    checkOutput("lh_trap_no_wen", {31'd0, regWen}, 32'd0);
    nextCycle();
`else
    runLoad("lh_unaligned", 3'b001, 32'h0000_0300, 32'h0000_0001, 5'd7, 0,
            32'h1234_8765, 32'h0000_0300, 32'hFFFF_8765);
`endif

    // Flush while waiting for a granted load's response.
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    checkOutput("fl_c0_hold", {31'd0, holdFlag}, 32'd1);
    nextCycle();
    gnt = 1'b1;
    @(negedge clk);
    checkOutput("fl_req", {31'd0, busReq}, 32'd1);
    nextCycle();
    gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    checkOutput("fl_wait_hold0", {31'd0, holdFlag}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      flush = 1'b0;
      @(negedge clk);
      checkOutput("fl_wait_hold", {31'd0, holdFlag}, 32'd1);
    end
    nextCycle();
    rvalid = 1'b1; rdata = 32'h1122_3344;
    @(negedge clk);
    checkOutput("fl_rvalid_hold", {31'd0, holdFlag}, 32'd0);
    nextCycle();
    rvalid = 1'b0; clearOp();
    @(negedge clk);
    checkOutput("fl_no_wen", {31'd0, regWen}, 32'd0);
    nextCycle();

    // Reset while a load is waiting for grant.
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'h0, 32'h0, 5'd3);
    nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rq_req_before_rst", {31'd0, busReq}, 32'd1);
    checkOutput("rq_hold_in_rst", {31'd0, holdFlag}, 32'd0);
    nextCycle();
    rst = 1'b0; clearOp();
    @(negedge clk);
    checkOutput("rq_req", {31'd0, busReq}, 32'd0);
    checkOutput("rq_addr", busAddr, 32'd0);
    checkOutput("rq_be", {28'd0, busBe}, 32'd0);
    checkOutput("rq_rd_data", rdDataOut, 32'd0);
    checkOutput("rq_hold", {31'd0, holdFlag}, 32'd0);
    nextCycle();
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checkOutput("rq_late_hold", {31'd0, holdFlag}, 32'd0);
    nextCycle();
    rvalid = 1'b0;
    @(negedge clk);
    checkOutput("rq_late_wen", {31'd0, regWen}, 32'd0);
    nextCycle();

    // Randomized traffic; the pipeline keeps an op presented while it is held.
    for (int i = 0; i < 4000; i++) begin
      int k;
      if (!expHoldLast || flushLast) begin
        k = $urandom_range(0, 9);
        memWe = (k < 4) || (k == 8);
        memRe = (k >= 4 && k < 9);
        if ($urandom_range(0, 7) == 0) memSize = 3'($urandom_range(0, 7));
        else begin
          k = $urandom_range(0, 4);
          memSize = (k == 3) ? 3'd4 : (k == 4) ? 3'd5 : 3'(k);
        end
        op1 = $urandom;
        op2 = $urandom;
        memData = $urandom;
        rdAddrIn = 5'($urandom_range(0, 31));
      end
      flush  = ($urandom_range(0, 9) == 0);
      gnt    = $urandom_range(0, 1) == 1;
      rvalid = (mPend && mGranted) ? ($urandom_range(0, 2) == 0)
                                   : (!mPend && $urandom_range(0, 9) == 0);
      rdata  = $urandom;
      rst    = ($urandom_range(0, 299) == 0);
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
